wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Registered, parametrised writeback stage that generalises the combinational writeback selector.
- Accepts one retiring instruction per handshake from the MEM stage.
- Selects the result source: next PC, ALU, load data or CSR.
- Aligns and sign/zero-extends sub-word loads.
- Waits on late memory responses.
- Drives a registered register-file write port plus hazard status back to decode.

Parameters:
XLEN, 32, datapath width in bits (32 or 64)
RADDR_W, 5, register-file address width
SRC_W, 2, width of the source-select field (4 sources)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept (combinational from state)
wb_src  in  SRC_W  0=next_pc, 1=alu_out, 2=memory, 3=csr_data
reg_write  in  1  instruction writes rd
rd  in  RADDR_W  destination register
next_pc  in  XLEN  PC+4
alu_out  in  XLEN  ALU result
csr_data  in  XLEN  CSR read value
ld_size  in  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only)
ld_unsigned  in  1  zero-extend when 1
ld_offset  in  3  byte address low bits (ALU address LSBs)
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  aligned-word load data
rf_we  out  1  register-file write enable
rf_waddr  out  RADDR_W  write address
rf_wdata  out  XLEN  write data
busy  out  1  a load is outstanding (WAIT_MEM)
busy_rd  out  RADDR_W  rd of the outstanding load, 0 when not busy
ld_misalign  out  1  one-cycle pulse on misaligned load

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - busy=0, busy_rd=0, ld_misalign=0
  - all latched fields cleared
- Reset asserted mid-load abandons the load. A mem_rvalid arriving after reset release while in IDLE is ignored.
- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0. Entered on accept with wb_src=2 and mem_rvalid=0.
- Accept = in_valid & in_ready. rf_* outputs are registered and update the cycle after the completing edge.
- Accept in IDLE with wb_src≠2:
  - Result is written next cycle (latency 1).
  - rf_we = reg_write & (rd≠0).
  - wb_src=3 selects csr_data.
- Accept with wb_src=2 and mem_rvalid=1 in the same cycle: completes like a non-load (latency 1), stays IDLE.
- Accept with wb_src=2 and mem_rvalid=0:
  - Latch rd, reg_write, ld_size, ld_unsigned, ld_offset.
  - Go to WAIT_MEM; busy=1; busy_rd=latched rd.
- WAIT_MEM:
  - On mem_rvalid=1: write the extended data next cycle, return to IDLE, busy drops with the same edge.
  - While mem_rvalid=0: hold; rf_we=0.
- rf_we is a single-cycle pulse per completing instruction. With no completion it is 0; rf_waddr and rf_wdata hold their last value.
- Load extraction:
  - lane = mem_rdata >> (8*offset).
  - byte: bits[7:0]; half: [15:0]; word: [31:0]; dword: full.
  - Extend to XLEN by sign bit, or by zero when ld_unsigned=1.
  - For XLEN=32, only ld_offset[1:0] is used, ld_size=3 is treated as word, and ld_unsigned is ignored for word.
- Misalignment: half with offset[0]=1, or word with offset[1:0]≠0 (XLEN=32), or the dword analogue.
  - Result: no write (rf_we=0), ld_misalign=1 for one cycle at the completion edge.
  - Checked at completion using the latched fields.
- rd=0 is never written, including loads. The data path still computes the value.
- in_valid while in_ready=0 is not accepted. Upstream must hold its inputs.

Decomposition:
- Shared cpu_pkg holds:
  - WB_SRC_PC/ALU/MEM/CSR constants
  - LD_BYTE/HALF/WORD/DWORD constants
  - wb_state_t enum (IDLE, WAIT_MEM)
- One sub-module, load_align: purely combinational. It takes data, size, unsigned and offset, and produces the extended value and the misalign flag. It is reused by the future store/AMO path.

Test Plan:
- ALU writeback: wb_src=1, alu_out=0x1234_5678, rd=5, reg_write=1 → next cycle rf_we=1, waddr=5, wdata=0x12345678; following cycle rf_we=0.
- rd=0 suppression: wb_src=0, next_pc=0x104, rd=0 → rf_we stays 0 throughout.
- Delayed signed byte load: wb_src=2, size=byte, offset=2, mem_rvalid low for 3 cycles then mem_rdata=0x0080_0000. Expected:
  - busy=1 and busy_rd=rd for 3 cycles, in_ready=0.
  - Then rf_wdata=0xFFFF_FF80, rf_we pulse, busy=0.
- Same-cycle unsigned half load: size=half, unsigned=1, offset=2, mem_rvalid=1, mem_rdata=0x8001_0000 → next cycle wdata=0x0000_8001, no WAIT_MEM entry.
- Misaligned word: size=word, offset=1, mem_rvalid=1 → ld_misalign pulses 1 cycle, rf_we=0.
- Reset mid-load: enter WAIT_MEM, assert rst asynchronously → all outputs 0 immediately; after release, stray mem_rvalid produces no write and in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback source codes, load sizes and writeback FSM states.
package cpu_pkg;

  localparam int unsigned WB_SRC_W = 2;
  localparam int unsigned LD_SIZE_W = 2;

  localparam logic [WB_SRC_W-1:0] WB_SRC_PC  = 2'd0;
  localparam logic [WB_SRC_W-1:0] WB_SRC_ALU = 2'd1;
  localparam logic [WB_SRC_W-1:0] WB_SRC_MEM = 2'd2;
  localparam logic [WB_SRC_W-1:0] WB_SRC_CSR = 2'd3;

  localparam logic [LD_SIZE_W-1:0] LD_BYTE  = 2'd0;
  localparam logic [LD_SIZE_W-1:0] LD_HALF  = 2'd1;
  localparam logic [LD_SIZE_W-1:0] LD_WORD  = 2'd2;
  localparam logic [LD_SIZE_W-1:0] LD_DWORD = 2'd3;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load lane extraction, sign/zero extension and misalignment detection.
module load_align
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]      i_data,
  input  logic [LD_SIZE_W-1:0] i_size,
  input  logic                 i_unsigned,
  input  logic [2:0]           i_offset,
  output logic [XLEN-1:0]      o_ext,
  output logic                 o_misalign
);

  logic [2:0]           w_off;
  logic [LD_SIZE_W-1:0] w_size;
  logic [XLEN-1:0]      w_lane;

  // RV32 only sees a 4-byte window and has no dword loads.
  always_comb begin
    w_off  = (XLEN == 64) ? i_offset : {1'b0, i_offset[1:0]};
    w_size = ((XLEN != 64) && (i_size == LD_DWORD)) ? LD_WORD : i_size;
    w_lane = i_data >> {w_off, 3'b000};
  end

  always_comb begin
    o_ext = w_lane;
    case (w_size)
      LD_BYTE: o_ext = i_unsigned ? XLEN'(w_lane[7:0]) : XLEN'($signed(w_lane[7:0]));
      LD_HALF: o_ext = i_unsigned ? XLEN'(w_lane[15:0]) : XLEN'($signed(w_lane[15:0]));
      LD_WORD: o_ext = (i_unsigned || (XLEN == 32)) ? XLEN'(w_lane[31:0])
                                                     : XLEN'($signed(w_lane[31:0]));
      default: o_ext = w_lane;
    endcase
  end

  always_comb begin
    o_misalign = 1'b0;
    case (w_size)
      LD_HALF:  o_misalign = w_off[0];
      LD_WORD:  o_misalign = |w_off[1:0];
      LD_DWORD: o_misalign = |w_off;
      default:  o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: result source select, load alignment, late-load wait
// and registered register-file write port with hazard status for decode.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned SRC_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SRC_W-1:0]   wb_src,
  input  logic               reg_write,
  input  logic [RADDR_W-1:0] rd,
  input  logic [XLEN-1:0]    next_pc,
  input  logic [XLEN-1:0]    alu_out,
  input  logic [XLEN-1:0]    csr_data,
  input  logic [1:0]         ld_size,
  input  logic               ld_unsigned,
  input  logic [2:0]         ld_offset,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               busy,
  output logic [RADDR_W-1:0] busy_rd,
  output logic               ld_misalign
);

  wb_state_t r_state, w_state_nxt;

  logic [RADDR_W-1:0]   r_rd, w_rd_nxt;
  logic                 r_reg_write, w_reg_write_nxt;
  logic [LD_SIZE_W-1:0] r_ld_size, w_ld_size_nxt;
  logic                 r_ld_unsigned, w_ld_unsigned_nxt;
  logic [2:0]           r_ld_offset, w_ld_offset_nxt;

  logic               r_rf_we, w_rf_we_nxt;
  logic [RADDR_W-1:0] r_rf_waddr, w_rf_waddr_nxt;
  logic [XLEN-1:0]    r_rf_wdata, w_rf_wdata_nxt;
  logic               r_busy, w_busy_nxt;
  logic [RADDR_W-1:0] r_busy_rd, w_busy_rd_nxt;
  logic               r_ld_misalign, w_ld_misalign_nxt;

  logic                 w_in_wait;
  logic                 w_accept;
  logic                 w_src_mem;
  logic [LD_SIZE_W-1:0] w_al_size;
  logic                 w_al_unsigned;
  logic [2:0]           w_al_offset;
  logic [XLEN-1:0]      w_ld_ext;
  logic                 w_ld_mis;
  logic [XLEN-1:0]      w_sel_data;

  assign w_in_wait = (r_state == WAIT_MEM);
  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_src_mem = (wb_src == SRC_W'(WB_SRC_MEM));

  // A waiting load is formatted from its latched attributes, not the live bus.
  assign w_al_size     = w_in_wait ? r_ld_size     : ld_size;
  assign w_al_unsigned = w_in_wait ? r_ld_unsigned : ld_unsigned;
  assign w_al_offset   = w_in_wait ? r_ld_offset   : ld_offset;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_data    (mem_rdata),
    .i_size    (w_al_size),
    .i_unsigned(w_al_unsigned),
    .i_offset  (w_al_offset),
    .o_ext     (w_ld_ext),
    .o_misalign(w_ld_mis)
  );

  always_comb begin
    w_sel_data = alu_out;
    case (wb_src)
      SRC_W'(WB_SRC_PC):  w_sel_data = next_pc;
      SRC_W'(WB_SRC_ALU): w_sel_data = alu_out;
      SRC_W'(WB_SRC_MEM): w_sel_data = w_ld_ext;
      SRC_W'(WB_SRC_CSR): w_sel_data = csr_data;
      default:            w_sel_data = alu_out;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_rd_nxt          = r_rd;
    w_reg_write_nxt   = r_reg_write;
    w_ld_size_nxt     = r_ld_size;
    w_ld_unsigned_nxt = r_ld_unsigned;
    w_ld_offset_nxt   = r_ld_offset;
    w_rf_we_nxt       = 1'b0;
    w_rf_waddr_nxt    = r_rf_waddr;
    w_rf_wdata_nxt    = r_rf_wdata;
    w_ld_misalign_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_src_mem && !mem_rvalid) begin
            w_state_nxt       = WAIT_MEM;
            w_rd_nxt          = rd;
            w_reg_write_nxt   = reg_write;
            w_ld_size_nxt     = ld_size;
            w_ld_unsigned_nxt = ld_unsigned;
            w_ld_offset_nxt   = ld_offset;
          end else begin
            w_rf_waddr_nxt    = rd;
            w_rf_wdata_nxt    = w_sel_data;
            w_rf_we_nxt       = reg_write & (|rd) & ~(w_src_mem & w_ld_mis);
            w_ld_misalign_nxt = w_src_mem & w_ld_mis;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          w_state_nxt       = IDLE;
          w_rf_waddr_nxt    = r_rd;
          w_rf_wdata_nxt    = w_ld_ext;
          w_rf_we_nxt       = r_reg_write & (|r_rd) & ~w_ld_mis;
          w_ld_misalign_nxt = w_ld_mis;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt    = (w_state_nxt == WAIT_MEM);
    w_busy_rd_nxt = w_busy_nxt ? w_rd_nxt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
      r_ld_size     <= '0;
      r_ld_unsigned <= 1'b0;
      r_ld_offset   <= '0;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_busy        <= 1'b0;
      r_busy_rd     <= '0;
      r_ld_misalign <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd          <= w_rd_nxt;
      r_reg_write   <= w_reg_write_nxt;
      r_ld_size     <= w_ld_size_nxt;
      r_ld_unsigned <= w_ld_unsigned_nxt;
      r_ld_offset   <= w_ld_offset_nxt;
      r_rf_we       <= w_rf_we_nxt;
      r_rf_waddr    <= w_rf_waddr_nxt;
      r_rf_wdata    <= w_rf_wdata_nxt;
      r_busy        <= w_busy_nxt;
      r_busy_rd     <= w_busy_rd_nxt;
      r_ld_misalign <= w_ld_misalign_nxt;
    end
  end

  assign rf_we       = r_rf_we;
  assign rf_waddr    = r_rf_waddr;
  assign rf_wdata    = r_rf_wdata;
  assign busy        = r_busy;
  assign busy_rd     = r_busy_rd;
  assign ld_misalign = r_ld_misalign;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push expected writebacks,
// a negedge monitor pops and compares them whenever the stage writes or flags misalignment.
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_src;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] next_pc;
  logic [31:0] alu_out;
  logic [31:0] csr_data;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [2:0]  ld_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic [4:0]  busy_rd;
  logic        ld_misalign;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  wb_stage #(.XLEN(32), .RADDR_W(5), .SRC_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_src(wb_src), .reg_write(reg_write), .rd(rd), .next_pc(next_pc),
    .alu_out(alu_out), .csr_data(csr_data), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_offset(ld_offset), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .busy_rd(busy_rd), .ld_misalign(ld_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic we, input logic [4:0] a, input logic [31:0] d,
                           input logic mis);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.mis = mis;
    exp_q.push_back(e);
  endtask

  // Only the selected source carries the payload; the others hold distinct junk.
  task automatic drive(input logic [1:0] src, input logic [4:0] r, input logic [1:0] sz,
                       input logic uns, input logic [2:0] off, input logic rv,
                       input logic [31:0] d);
    in_valid    = 1'b1;
    reg_write   = 1'b1;
    wb_src      = src;
    rd          = r;
    ld_size     = sz;
    ld_unsigned = uns;
    ld_offset   = off;
    mem_rvalid  = rv;
    next_pc     = (src == WB_SRC_PC)  ? d : 32'h0BAD_0000;
    alu_out     = (src == WB_SRC_ALU) ? d : 32'h0BAD_0001;
    mem_rdata   = (src == WB_SRC_MEM) ? d : 32'h0BAD_0002;
    csr_data    = (src == WB_SRC_CSR) ? d : 32'h0BAD_0003;
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    reg_write  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Monitor: every write or misalign pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (rf_we || ld_misalign)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wb: we=%0b addr=%0d data=0x%08h mis=%0b expected none",
                 rf_we, rf_waddr, rf_wdata, ld_misalign);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_we", 32'(rf_we), 32'(e.we));
        if (e.we) begin
          check("wb_addr", 32'(rf_waddr), 32'(e.addr));
          check("wb_data", rf_wdata, e.data);
        end
        check("wb_misalign", 32'(ld_misalign), 32'(e.mis));
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; reg_write = 1'b0; wb_src = '0; rd = '0;
    next_pc = '0; alu_out = '0; csr_data = '0; ld_size = '0;
    ld_unsigned = 1'b0; ld_offset = '0; mem_rvalid = 1'b0; mem_rdata = '0;

    @(negedge clk);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_busy_rd", 32'(busy_rd), 32'd0);
    check("rst_misalign", 32'(ld_misalign), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU writeback, then the write pulse must drop.
    drive(WB_SRC_ALU, 5'd5, LD_WORD, 1'b0, 3'd0, 1'b0, 32'h1234_5678);
    expect_wb(1'b1, 5'd5, 32'h1234_5678, 1'b0);
    accept();
    @(posedge clk);
    @(negedge clk);
    check("alu_we_drop", 32'(rf_we), 32'd0);

    // rd=0 is never written.
    drive(WB_SRC_PC, 5'd0, LD_WORD, 1'b0, 3'd0, 1'b0, 32'h0000_0104);
    accept();
    @(negedge clk);
    check("rd0_no_write", 32'(rf_we), 32'd0);

    drive(WB_SRC_CSR, 5'd31, LD_WORD, 1'b0, 3'd0, 1'b0, 32'hA5A5_0001);
    expect_wb(1'b1, 5'd31, 32'hA5A5_0001, 1'b0);
    accept();

    // Delayed signed byte load with a stalled ALU instruction behind it.
    drive(WB_SRC_MEM, 5'd7, LD_BYTE, 1'b0, 3'd2, 1'b0, 32'h0080_0000);
    expect_wb(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
    @(posedge clk);
    #1;
    wb_src  = WB_SRC_ALU;
    rd      = 5'd9;
    alu_out = 32'hCAFE_0009;
    expect_wb(1'b1, 5'd9, 32'hCAFE_0009, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_busy", 32'(busy), 32'd1);
      check("ld_busy_rd", 32'(busy_rd), 32'd7);
      check("ld_in_ready", 32'(in_ready), 32'd0);
      if (i < 2) @(posedge clk);
    end
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1 mem_rvalid = 1'b0;
    @(negedge clk);
    check("ld_busy_drop", 32'(busy), 32'd0);
    check("ld_busy_rd_drop", 32'(busy_rd), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    reg_write = 1'b0;

    // Same-cycle loads complete without entering the wait state.
    drive(WB_SRC_MEM, 5'd3, LD_HALF, 1'b1, 3'd2, 1'b1, 32'h8001_0000);
    expect_wb(1'b1, 5'd3, 32'h0000_8001, 1'b0);
    accept();
    @(negedge clk);
    check("hu_no_busy", 32'(busy), 32'd0);
    check("hu_in_ready", 32'(in_ready), 32'd1);

    drive(WB_SRC_MEM, 5'd4, LD_HALF, 1'b0, 3'd2, 1'b1, 32'h8001_0000);
    expect_wb(1'b1, 5'd4, 32'hFFFF_8001, 1'b0);
    accept();
    drive(WB_SRC_MEM, 5'd6, LD_WORD, 1'b1, 3'd0, 1'b1, 32'hDEAD_BEEF);
    expect_wb(1'b1, 5'd6, 32'hDEAD_BEEF, 1'b0);
    accept();
    drive(WB_SRC_MEM, 5'd11, LD_DWORD, 1'b0, 3'd0, 1'b1, 32'h1122_3344);
    expect_wb(1'b1, 5'd11, 32'h1122_3344, 1'b0);
    accept();

    // Misaligned word: one-cycle flag, no write.
    drive(WB_SRC_MEM, 5'd8, LD_WORD, 1'b0, 3'd1, 1'b1, 32'h1234_5678);
    expect_wb(1'b0, 5'd0, 32'd0, 1'b1);
    accept();
    @(posedge clk);
    @(negedge clk);
    check("mis_pulse_end", 32'(ld_misalign), 32'd0);

    // Delayed misaligned half: live attributes change, latched ones must rule.
    drive(WB_SRC_MEM, 5'd12, LD_HALF, 1'b0, 3'd3, 1'b0, 32'hFFFF_0000);
    expect_wb(1'b0, 5'd0, 32'd0, 1'b1);
    accept();
    ld_size   = LD_BYTE;
    ld_offset = 3'd0;
    @(posedge clk);
    #1 mem_rvalid = 1'b1;
    @(posedge clk);
    #1 mem_rvalid = 1'b0;

    // Load to rd=0 is suppressed.
    drive(WB_SRC_MEM, 5'd0, LD_WORD, 1'b0, 3'd0, 1'b1, 32'h0000_0055);
    accept();
    @(negedge clk);
    check("ld_rd0_no_write", 32'(rf_we), 32'd0);

    // Reset in the middle of an outstanding load.
    drive(WB_SRC_MEM, 5'd10, LD_BYTE, 1'b0, 3'd0, 1'b0, 32'h0000_0077);
    accept();
    @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_rf_we", 32'(rf_we), 32'd0);
    check("arst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("arst_rf_wdata", rf_wdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_busy_rd", 32'(busy_rd), 32'd0);
    check("arst_misalign", 32'(ld_misalign), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_rvalid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 mem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rvalid_no_write", 32'(rf_we), 32'd0);
    check("stray_rvalid_in_ready", 32'(in_ready), 32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
